// File: rtl/sobel_if.sv
// Window/result bundle for the Sobel edge operator: nine 8-bit pixels in, one 8-bit magnitude out.
// The master presents the window, and the slave returns the registered edge strength.
interface sobel_if;
  logic [7:0] din0;
  logic [7:0] din1;
  logic [7:0] din2;
  logic [7:0] din3;
  logic [7:0] din4;
  logic [7:0] din5;
  logic [7:0] din6;
  logic [7:0] din7;
  logic [7:0] din8;
  logic [7:0] dout;

  modport master (
    output din0, din1, din2, din3, din4, din5, din6, din7, din8,
    input  dout
  );

  modport slave (
    input  din0, din1, din2, din3, din4, din5, din6, din7, din8,
    output dout
  );
endinterface

// File: rtl/sobel.sv
// 3x3 Sobel edge magnitude: |Gx| + |Gy| saturated to 255, one window per clock, 1-cycle latency.
// The datapath is combinational up to a single output register that is cleared asynchronously.
module sobel (
  input  logic    clk,
  input  logic    rst_n,
  sobel_if.slave  bus
);

  logic [9:0]         gx_pos;
  logic [9:0]         gx_neg;
  logic [9:0]         gy_pos;
  logic [9:0]         gy_neg;
  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic [10:0]        gx_negated;
  logic [10:0]        gy_negated;
  logic [9:0]         abs_gx;
  logic [9:0]         abs_gy;
  logic [10:0]        mag;
  logic [7:0]         dout_d;
  logic [7:0]         dout_q;
  logic               unused_centre;

  // The centre pixel carries no weight in either kernel.
  assign unused_centre = ^bus.din4;

  // Weighted row and column sums, each at most 4*255 = 1020.
  assign gx_pos = {2'b00, bus.din2} + {1'b0, bus.din5, 1'b0} + {2'b00, bus.din8};
  assign gx_neg = {2'b00, bus.din0} + {1'b0, bus.din3, 1'b0} + {2'b00, bus.din6};
  assign gy_pos = {2'b00, bus.din6} + {1'b0, bus.din7, 1'b0} + {2'b00, bus.din8};
  assign gy_neg = {2'b00, bus.din0} + {1'b0, bus.din1, 1'b0} + {2'b00, bus.din2};

  assign gx = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
  assign gy = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});

  always_comb begin
    gx_negated = 11'(-gx);
    gy_negated = 11'(-gy);
    abs_gx     = gx[10] ? gx_negated[9:0] : gx[9:0];
    abs_gy     = gy[10] ? gy_negated[9:0] : gy[9:0];
    mag        = {1'b0, abs_gx} + {1'b0, abs_gy};
    // Clamp rather than wrap, so strong edges never read as weak ones.
    dout_d     = (mag > 11'd255) ? 8'hFF : mag[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 8'h00;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_sobel.sv
// Directed and random check of the Sobel operator against an arithmetic reference model.
// The model evaluates the kernel with plain integers.
module tb_sobel;

  typedef int win_t [9];

  logic clk;
  logic rst_n;
  logic run;
  int   vectors;
  int   miscompares;

  sobel_if ifc ();

  sobel dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (run) clk = ~clk;
    end
  end

  function automatic int ref_sobel(input win_t p);
    int gx;
    int gy;
    int mag;
    gx  = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
    gy  = (p[6] + 2 * p[7] + p[8]) - (p[0] + 2 * p[1] + p[2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag > 255) ? 255 : mag;
  endfunction

  task automatic drive(input win_t w);
    ifc.din0 = 8'(w[0]);
    ifc.din1 = 8'(w[1]);
    ifc.din2 = 8'(w[2]);
    ifc.din3 = 8'(w[3]);
    ifc.din4 = 8'(w[4]);
    ifc.din5 = 8'(w[5]);
    ifc.din6 = 8'(w[6]);
    ifc.din7 = 8'(w[7]);
    ifc.din8 = 8'(w[8]);
  endtask

  task automatic check(input string tag, input int expected);
    logic [7:0] exp8;
    exp8 = 8'(expected);
    vectors++;
    assert (ifc.dout === exp8)
    else begin
      miscompares++;
      $error("FAIL %s: dout=%0d expected=%0d", tag, ifc.dout, exp8);
    end
    $display("[%0t] %s dout=%0d expected=%0d", $time, tag, ifc.dout, exp8);
  endtask

  // Presents a window on the falling edge and checks its result one edge later.
  task automatic step(input string tag, input win_t w);
    drive(w);
    @(negedge clk);
    check(tag, ref_sobel(w));
  endtask

  win_t w_flat, w_vert, w_diag, w_satx, w_saty, w_zero, w_full, w_mix, w_r;

  initial begin
    vectors     = 0;
    miscompares = 0;
    run         = 1'b0;
    rst_n       = 1'b1;

    w_flat = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    w_vert = '{0, 0, 10, 0, 0, 10, 0, 0, 10};
    w_diag = '{0, 0, 0, 0, 0, 0, 0, 0, 50};
    w_satx = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
    w_saty = '{255, 255, 255, 0, 0, 0, 0, 0, 0};
    w_zero = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    w_full = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    w_mix  = '{255, 255, 0, 255, 0, 0, 0, 0, 0};

    // Reset with the clock stopped and non-zero inputs.
    drive(w_satx);
    #2 rst_n = 1'b0;
    #1 check("reset_async", 0);
    #3 rst_n = 1'b1;
    #2 check("release_hold", 0);

    drive(w_flat);
    run = 1'b1;
    @(negedge clk);
    check("flat", 0);

    // Back-to-back streaming: results follow one cycle behind the inputs.
    step("vertical_edge", w_vert);
    step("diagonal", w_diag);
    step("saturate_gx", w_satx);
    step("saturate_gy", w_saty);
    step("all_zero", w_zero);
    step("all_255", w_full);
    step("max_diagonal", w_mix);

    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < 9; k++) begin
        w_r[k] = (i % 2 == 0) ? int'($urandom_range(0, 255)) : 100 + int'($urandom_range(0, 30));
      end
      step("random", w_r);
    end

    // Mid-cycle reset pulse: output clears at once and resumes on the next edge.
    drive(w_vert);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("midstream_reset", 0);
    drive(w_diag);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_release_hold", 0);
    @(negedge clk);
    check("resume_diagonal", ref_sobel(w_diag));
    step("resume_saturate", w_satx);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
